v_hier_subsub_pipe: RTL and testbench

//   Parametrised leaf stage of the hier test hierarchy. Carries a WIDTH-bit word from a to q through

---
 rtl/v_hier_pkg.sv | 12 +
 rtl/v_hier_pipe_stage.sv | 36 +++
 rtl/v_hier_subsub_pipe.sv | 99 +++++++++
 tb/tb_v_hier_subsub_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/v_hier_pkg.sv
// Shared definitions for the hier pipeline slice: mode encodings and the
// occupancy-counter width helper.
package v_hier_pkg;

  localparam logic MODE_PIPE = 1'b0;
  localparam logic MODE_BYP  = 1'b1;

  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/v_hier_pipe_stage.sv
// One elastic register slot: holds a word until the downstream side takes it.
// Handshake: a word moves when valid & ready are both high at the rising edge.
module v_hier_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Empty slots always accept; a full slot accepts only while it is being drained.
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/v_hier_subsub_pipe.sv
// Leaf stage of the hier hierarchy: DEPTH elastic stages with a zero-latency
// bypass mode, synchronous flush and an occupancy counter.
module v_hier_subsub_pipe
  import v_hier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             bypass,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic [OCC_W-1:0] occupancy,
  output logic             busy
);

  logic                        mode_r;
  logic                        mode_nxt;
  logic [DEPTH:0]              v_chain;
  logic [DEPTH:0]              r_chain;
  logic [DEPTH:0][WIDTH-1:0]   d_chain;
  logic                        gate_in;
  logic                        push;
  logic                        pop;
  logic [OCC_W-1:0]            occ_r;

  // A pending bypass request blocks new input so the stages drain before the switch.
  assign gate_in    = ~flush & ~(bypass & busy);
  assign v_chain[0] = a_valid & gate_in & (mode_r == MODE_PIPE);
  assign d_chain[0] = a;
  assign r_chain[DEPTH] = q_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    v_hier_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (v_chain[g]),
      .in_ready  (r_chain[g]),
      .in_data   (d_chain[g]),
      .out_valid (v_chain[g+1]),
      .out_ready (r_chain[g+1]),
      .out_data  (d_chain[g+1])
    );
  end

  assign push = v_chain[0] & r_chain[0];
  assign pop  = v_chain[DEPTH] & q_ready & (mode_r == MODE_PIPE);

  always_comb begin
    q       = d_chain[DEPTH];
    q_valid = v_chain[DEPTH];
    a_ready = r_chain[0] & gate_in;
    if (mode_r == MODE_BYP) begin
      q       = a;
      q_valid = a_valid;
      a_ready = q_ready & ~flush;
    end
  end

  // Mode only changes while the stages are empty and nothing is entering them.
  always_comb begin
    mode_nxt = mode_r;
    if ((occ_r == '0) && !push) begin
      mode_nxt = bypass ? MODE_BYP : MODE_PIPE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= MODE_PIPE;
    end else begin
      mode_r <= mode_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= '0;
    end else if (flush) begin
      occ_r <= '0;
    end else if (push && !pop) begin
      occ_r <= occ_r + 1'b1;
    end else if (pop && !push) begin
      occ_r <= occ_r - 1'b1;
    end
  end

  assign occupancy = occ_r;
  assign busy      = (occ_r != '0);

endmodule

// File: tb/tb_v_hier_subsub_pipe.sv
// Directed bench for v_hier_subsub_pipe: main 8x2 instance plus 1x1 and 32x4 variants.
module tb_v_hier_subsub_pipe;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance: WIDTH=8, DEPTH=2
  logic       flush, bypass, a_valid, a_ready, q_valid, q_ready, busy;
  logic [7:0] a, q;
  logic [1:0] occupancy;

  // small variant: WIDTH=1, DEPTH=1
  logic s_flush, s_bypass, s_a_valid, s_a_ready, s_q_valid, s_q_ready, s_busy;
  logic [0:0] s_a, s_q;
  logic [0:0] s_occ;

  // wide variant: WIDTH=32, DEPTH=4
  logic        w_flush, w_bypass, w_a_valid, w_a_ready, w_q_valid, w_q_ready, w_busy;
  logic [31:0] w_a, w_q;
  logic [2:0]  w_occ;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_q_s[$];
  logic [31:0] exp_q_w[$];

  v_hier_subsub_pipe #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bypass(bypass),
    .a_valid(a_valid), .a_ready(a_ready), .a(a),
    .q_valid(q_valid), .q_ready(q_ready), .q(q),
    .occupancy(occupancy), .busy(busy)
  );

  v_hier_subsub_pipe #(.WIDTH(1), .DEPTH(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .bypass(s_bypass),
    .a_valid(s_a_valid), .a_ready(s_a_ready), .a(s_a),
    .q_valid(s_q_valid), .q_ready(s_q_ready), .q(s_q),
    .occupancy(s_occ), .busy(s_busy)
  );

  v_hier_subsub_pipe #(.WIDTH(32), .DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(w_flush), .bypass(w_bypass),
    .a_valid(w_a_valid), .a_ready(w_a_ready), .a(w_a),
    .q_valid(w_q_valid), .q_ready(w_q_ready), .q(w_q),
    .occupancy(w_occ), .busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
  endtask

  logic [7:0] s_pat;
  logic [31:0] exp_word;

  initial begin
    s_pat = 8'b0100_1101;
    flush = 1'b0; bypass = 1'b0; a_valid = 1'b1; a = 8'hA5; q_ready = 1'b1;
    s_flush = 1'b0; s_bypass = 1'b0; s_a_valid = 1'b0; s_a = 1'b0; s_q_ready = 1'b1;
    w_flush = 1'b0; w_bypass = 1'b0; w_a_valid = 1'b0; w_a = '0; w_q_ready = 1'b1;

    // 1: reset with input pending
    repeat (3) wait_neg();
    check("rst_q_valid", 32'(q_valid), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_occ", 32'(occupancy), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_a_ready", 32'(a_ready), 32'h1);
    flush = 1'b1;
    #1 check("rst_a_ready_flush", 32'(a_ready), 32'h0);
    flush = 1'b0;
    a_valid = 1'b0;
    wait_neg();
    rst_n = 1'b1;
    wait_neg();

    // 2: back-to-back stream 01..10
    for (int i = 0; i < 16; i++) begin
      a = 8'(i + 1);
      a_valid = 1'b1;
      check("strm_a_ready", 32'(a_ready), 32'h1);
      wait_neg();
      if (i == 0) begin
        check("strm_first_q_valid", 32'(q_valid), 32'h0);
        check("strm_first_occ", 32'(occupancy), 32'h1);
      end else begin
        check("strm_q_valid", 32'(q_valid), 32'h1);
        check("strm_q", 32'(q), 32'(i));
        check("strm_occ", 32'(occupancy), 32'h2);
      end
    end
    a_valid = 1'b0;
    wait_neg();
    check("strm_last_q", 32'(q), 32'h10);
    check("strm_last_occ", 32'(occupancy), 32'h1);
    wait_neg();
    check("strm_empty_q_valid", 32'(q_valid), 32'h0);
    check("strm_empty_busy", 32'(busy), 32'h0);

    // 3: backpressure
    a = 8'h21; a_valid = 1'b1;
    wait_neg();
    a = 8'h22;
    wait_neg();
    check("bp_fill_occ", 32'(occupancy), 32'h2);
    q_ready = 1'b0;
    a = 8'h23;
    #1 check("bp_a_ready", 32'(a_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      wait_neg();
      check("bp_hold_occ", 32'(occupancy), 32'h2);
      check("bp_hold_q", 32'(q), 32'h21);
      check("bp_hold_q_valid", 32'(q_valid), 32'h1);
      check("bp_hold_a_ready", 32'(a_ready), 32'h0);
    end
    q_ready = 1'b1;
    #1 check("bp_release_a_ready", 32'(a_ready), 32'h1);
    wait_neg();
    check("bp_resume_q", 32'(q), 32'h22);
    a_valid = 1'b0;
    wait_neg();
    check("bp_resume_q2", 32'(q), 32'h23);
    check("bp_resume_occ", 32'(occupancy), 32'h1);
    wait_neg();
    check("bp_drain_q_valid", 32'(q_valid), 32'h0);

    // 4: mode switch while pipe holds two words
    q_ready = 1'b0; a_valid = 1'b1; a = 8'h41;
    wait_neg();
    a = 8'h42;
    wait_neg();
    check("mode_fill_occ", 32'(occupancy), 32'h2);
    bypass = 1'b1; q_ready = 1'b1; a = 8'h43;
    #1 check("mode_block_a_ready", 32'(a_ready), 32'h0);
    a_valid = 1'b0;
    wait_neg();
    check("mode_drain_q", 32'(q), 32'h42);
    check("mode_drain_a_ready", 32'(a_ready), 32'h0);
    wait_neg();
    check("mode_drained_occ", 32'(occupancy), 32'h0);
    wait_neg();
    a = 8'h3C; a_valid = 1'b1;
    #1 check("byp_q", 32'(q), 32'h3C);
    check("byp_q_valid", 32'(q_valid), 32'h1);
    check("byp_a_ready", 32'(a_ready), 32'h1);
    q_ready = 1'b0;
    #1 check("byp_a_ready_stall", 32'(a_ready), 32'h0);
    q_ready = 1'b1;
    wait_neg();
    check("byp_occ", 32'(occupancy), 32'h0);
    bypass = 1'b0; a_valid = 1'b0;
    wait_neg();
    a = 8'h44; a_valid = 1'b1;
    #1 check("pipe_back_q_valid", 32'(q_valid), 32'h0);
    a_valid = 1'b0;
    wait_neg();

    // 5: flush with a full pipe and input pending
    q_ready = 1'b0; a_valid = 1'b1; a = 8'h51;
    wait_neg();
    a = 8'h52;
    wait_neg();
    check("fl_fill_occ", 32'(occupancy), 32'h2);
    flush = 1'b1; a = 8'h53;
    #1 check("fl_a_ready", 32'(a_ready), 32'h0);
    wait_neg();
    flush = 1'b0;
    check("fl_occ", 32'(occupancy), 32'h0);
    check("fl_q_valid", 32'(q_valid), 32'h0);
    check("fl_busy", 32'(busy), 32'h0);
    a = 8'h54; q_ready = 1'b1;
    #1 check("fl_after_a_ready", 32'(a_ready), 32'h1);
    wait_neg();
    check("fl_next_occ", 32'(occupancy), 32'h1);
    a_valid = 1'b0;
    wait_neg();
    check("fl_next_q_valid", 32'(q_valid), 32'h1);
    check("fl_next_q", 32'(q), 32'h54);
    wait_neg();
    check("fl_empty_q_valid", 32'(q_valid), 32'h0);

    // 6: async reset mid-stream, then fresh streams on all instances
    q_ready = 1'b0; a_valid = 1'b1; a = 8'h61;
    wait_neg();
    a = 8'h62;
    wait_neg();
    check("ar_pre_q_valid", 32'(q_valid), 32'h1);
    a_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("ar_q_valid", 32'(q_valid), 32'h0);
    check("ar_q", 32'(q), 32'h0);
    check("ar_occ", 32'(occupancy), 32'h0);
    #1 rst_n = 1'b1;
    wait_neg();
    q_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 8) begin
        a = 8'h70 + 8'(c); a_valid = 1'b1;
        s_a = s_pat[c-1]; s_a_valid = 1'b1;
        w_a = 32'hDEAD_0000 + 32'(c); w_a_valid = 1'b1;
        exp_q.push_back(32'(a));
        exp_q_s.push_back(32'(s_a));
        exp_q_w.push_back(w_a);
        check("fr_a_ready", 32'(a_ready), 32'h1);
        check("fr_s_a_ready", 32'(s_a_ready), 32'h1);
        check("fr_w_a_ready", 32'(w_a_ready), 32'h1);
      end else begin
        a_valid = 1'b0; s_a_valid = 1'b0; w_a_valid = 1'b0;
      end
      wait_neg();
      check("fr_q_valid", 32'(q_valid), 32'((c >= 2) && (c <= 9)));
      if ((c >= 2) && (c <= 9) && (exp_q.size() > 0)) begin
        exp_word = exp_q.pop_front();
        check("fr_q", 32'(q), exp_word);
      end
      check("fr_s_q_valid", 32'(s_q_valid), 32'(c <= 8));
      if ((c <= 8) && (exp_q_s.size() > 0)) begin
        exp_word = exp_q_s.pop_front();
        check("fr_s_q", 32'(s_q), exp_word);
      end
      check("fr_w_q_valid", 32'(w_q_valid), 32'((c >= 4) && (c <= 11)));
      check("fr_w_occ", 32'(w_occ),
            32'(((c < 8) ? c : 8) - ((c <= 4) ? 0 : (((c - 4) < 8) ? (c - 4) : 8))));
      if ((c >= 4) && (c <= 11) && (exp_q_w.size() > 0)) begin
        exp_word = exp_q_w.pop_front();
        check("fr_w_q", w_q, exp_word);
      end
    end
    check("fr_main_left", 32'(exp_q.size()), 32'h0);
    check("fr_s_left", 32'(exp_q_s.size()), 32'h0);
    check("fr_w_left", 32'(exp_q_w.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
